serdes_link_mon: RTL



---
 rtl/serdes_link_mon.sv | 133 +++++++++++++
 1 files changed

// File: rtl/serdes_link_mon.sv
`default_nettype none
// ============================================================================
// Module   : serdes_link_mon
// Brief    : SerDes bring-up supervisor: reset pulse, lock qualify, bounded retry
// Revision : 1.0 - initial release
// ============================================================================
module serdes_link_mon #(
  parameter int RST_PULSE    = 270,
  parameter int LOCK_STABLE  = 27000,
  parameter int LOCK_TIMEOUT = 8100000,
  parameter int MAX_RETRY    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lock_i,
  output logic       serdes_rst_o,
  output logic       link_ok_o,
  output logic [3:0] retry_cnt_o,
  output logic       fail_o
);

  localparam logic [27:0] c_PLS_LAST = 28'(RST_PULSE - 1);
  localparam logic [27:0] c_STB_LAST = 28'(LOCK_STABLE - 1);
  localparam logic [27:0] c_TMO_LAST = 28'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]  c_MAX_RETRY = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_PULSE  = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_LINKED = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [27:0] r_pls_cnt, w_pls_nxt;
  logic [27:0] r_tmo_cnt, w_tmo_nxt;
  logic [27:0] r_stb_cnt, w_stb_nxt;
  logic [3:0]  r_retry, w_retry_nxt;
  logic        r_lock_meta, r_lock_s;
  logic        w_retry_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_PULSE;
      r_pls_cnt   <= '0;
      r_tmo_cnt   <= '0;
      r_stb_cnt   <= '0;
      r_retry     <= '0;
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pls_cnt   <= w_pls_nxt;
      r_tmo_cnt   <= w_tmo_nxt;
      r_stb_cnt   <= w_stb_nxt;
      r_retry     <= w_retry_nxt;
      r_lock_meta <= lock_i;
      r_lock_s    <= r_lock_meta;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pls_nxt   = r_pls_cnt;
    w_tmo_nxt   = r_tmo_cnt;
    w_stb_nxt   = r_stb_cnt;
    w_retry_nxt = r_retry;
    w_retry_req = 1'b0;
    case (r_state)
      S_PULSE: begin
        w_pls_nxt = r_pls_cnt + 28'd1;
        if (r_pls_cnt == c_PLS_LAST) begin
          w_state_nxt = S_WAIT;
          w_pls_nxt   = '0;
          w_tmo_nxt   = '0;
        end
      end
      S_WAIT: begin
        w_tmo_nxt = r_tmo_cnt + 28'd1;
        if (r_lock_s) begin
          w_state_nxt = S_STABLE;
          w_stb_nxt   = '0;
        end else if (r_tmo_cnt >= c_TMO_LAST) begin
          w_retry_req = 1'b1;
        end
      end
      S_STABLE: begin
        // >= so a timeout deferred by a lock edge in WAIT still fires here
        w_tmo_nxt = r_tmo_cnt + 28'd1;
        if (r_lock_s) w_stb_nxt = r_stb_cnt + 28'd1;
        if (r_lock_s && (r_stb_cnt == c_STB_LAST)) begin
          w_state_nxt = S_LINKED;
          w_retry_nxt = '0;
        end else if (r_tmo_cnt >= c_TMO_LAST) begin
          w_retry_req = 1'b1;
        end else if (!r_lock_s) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_LINKED: begin
        if (!r_lock_s) begin
          w_state_nxt = S_PULSE;
          w_retry_nxt = 4'd1;
          w_pls_nxt   = '0;
        end
      end
      S_FAIL: begin
        w_state_nxt = S_FAIL;
      end
      default: begin
        w_state_nxt = S_PULSE;
        w_pls_nxt   = '0;
      end
    endcase
    if (w_retry_req) begin
      if (r_retry == c_MAX_RETRY) begin
        w_state_nxt = S_FAIL;
      end else begin
        w_retry_nxt = r_retry + 4'd1;
        w_state_nxt = S_PULSE;
        w_pls_nxt   = '0;
      end
    end
  end

  assign serdes_rst_o = (r_state == S_PULSE) || (r_state == S_FAIL);
  assign link_ok_o    = (r_state == S_LINKED);
  assign fail_o       = (r_state == S_FAIL);
  assign retry_cnt_o  = r_retry;

endmodule
`default_nettype wire
